iso14443a_crc_a: RTL and testbench
==================================

# iso14443a_crc_a

Serial CRC_A generator for the ISO/IEC 14443-3 Type A receive and transmit paths. It consumes one data bit per `sample` strobe, least-significant bit of each byte first. It maintains the 16-bit CRC_A (polynomial x^16 + x^12 + x^5 + 1, reflected, preset 0x6363, no final XOR) as a registered output. Framing logic uses it to check received frames (CRC over data plus received CRC equals 0x0000) and to generate CRC bytes for transmission.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  synchronous re-initialise; preset CRC to 0x6363 at next edge.
- `data`  in  1  serial data bit; only meaningful when `sample`=1.
- `sample`  in  1  strobe; fold `data` into the CRC at this edge.
- `crc`  out  16  current CRC register value, directly from flops; bit 0 is LSB of the low CRC byte.

## Operation
- State is a single 16-bit register R, driven directly onto `crc`.
- Reset (`rst_n`=0): R = 0x6363 immediately, independent of `clk`.
- Each rising edge, priority order:
  - `start`=1: R <= 0x6363. Any `data`/`sample` in the same cycle is ignored.
  - else `sample`=1: fb = `data` ^ R[0]; R <= (R >> 1) ^ (fb ? 0x8408 : 0x0000).
  - else: R holds.
- Equivalent per-bit update, using the old R on the right-hand side:
  - R[15] = fb.
  - R[10] = R[11] ^ fb.
  - R[3] = R[4] ^ fb.
  - All other bits: R[i] = R[i+1].
- Bit ordering:
  - Bytes are presented LSB first, bytes in transmission order.
  - Result is transmitted low byte `crc[7:0]` first, then `crc[15:8]`.
- Self-check property: feed a message followed by its CRC (low byte first, each LSB first). R then equals 0x0000.
- No data presented after `start`: R stays 0x6363.
- Arbitrary message length; no internal bit or byte counter.
- Purely synchronous datapath apart from the asynchronous reset. No combinational path from inputs to `crc`.

## Timing
- Latency: 1 clock. `crc` reflects a bit sampled at edge N immediately after edge N.
- `sample` is level-qualified per cycle and need not be a single-cycle pulse. Each cycle with `sample`=1 (and `start`=0) consumes exactly one bit.
  - Back-to-back sampling every cycle is supported.
  - Gaps of any length between samples are allowed.
- `start` may be asserted for one or more cycles. R = 0x6363 after the last cycle with `start`=1.
- Reset mid-message discards all accumulated state (R = 0x6363). Operation resumes normally after `rst_n` deasserts; no `start` is needed.
- `start` mid-message behaves the same as reset, synchronously.
- Reset value of `crc`: 0x6363.

## Test plan
- Reset, pulse `start`, no data: `crc` = 0x6363.
- `start`, then bytes 0x00, 0x00 (16 zero bits, one `sample` every other cycle): `crc` = 0x1EA0.
- `start`, then bytes 0x12, 0x34, LSB first: `crc` = 0xCF26.
- 1000 random messages of 0–10 bytes:
  - `crc` matches the byte-wise reference model (ISO 14443-3 Annex B algorithm) and the bitwise LFSR model.
  - Re-running with the CRC appended (low byte first) gives `crc` = 0x0000.
- `start` and `sample`=1 asserted in the same cycle after partial data: `crc` = 0x6363 (sample ignored).
- Continuous `sample` every cycle for 0x12, 0x34: `crc` = 0xCF26. Assert `rst_n`=0 mid-message: `crc` returns to 0x6363 asynchronously.

Source files
------------

// File: rtl/iso14443a_crc_a.sv
// Serial CRC_A (x^16 + x^12 + x^5 + 1, reflected, preset 0x6363) for ISO/IEC 14443-3 Type A.
// One bit is folded in per sample strobe, LSB of each byte first; crc comes straight from flops.
module iso14443a_crc_a (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        data,
    input  logic        sample,
    output logic [15:0] crc
);

    localparam logic [15:0] CRC_PRESET = 16'h6363;
    localparam logic [15:0] CRC_POLY_R = 16'h8408;

    logic [15:0] crc_p0;
    logic [15:0] crc_nxt;

    // One reflected LFSR step: shift right, fold the poly in when the bit leaving meets a 1.
    function automatic logic [15:0] crc_step(input logic [15:0] r, input logic b);
        logic fb;
        fb = b ^ r[0];
        return (r >> 1) ^ (fb ? CRC_POLY_R : 16'h0000);
    endfunction

    always_comb begin
        crc_nxt = crc_p0;
        if (start) begin
            crc_nxt = CRC_PRESET;
        end else if (sample) begin
            crc_nxt = crc_step(crc_p0, data);
        end
    end

    // Stage p0: CRC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_p0 <= CRC_PRESET;
        end else begin
            crc_p0 <= crc_nxt;
        end
    end

    assign crc = crc_p0;

endmodule

// File: tb/tb_iso14443a_crc_a.sv
// Randomised self-checking bench for iso14443a_crc_a against byte-wise and bit-wise CRC_A models.
module tb_iso14443a_crc_a;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        data;
    logic        sample;
    logic [15:0] crc;

    int n_checks = 0;
    int n_fail   = 0;

    iso14443a_crc_a dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .data  (data),
        .sample(sample),
        .crc   (crc)
    );

    always #5 clk = ~clk;

    // ISO 14443-3 Annex B byte-wise algorithm.
    function automatic logic [15:0] ref_bytes(input logic [7:0] msg[$]);
        logic [15:0] w;
        logic [7:0]  ch;
        w = 16'h6363;
        foreach (msg[k]) begin
            ch = msg[k] ^ w[7:0];
            ch = ch ^ {ch[3:0], 4'h0};
            w  = {8'h00, w[15:8]} ^ {ch, 8'h00} ^ {5'h00, ch, 3'h0} ^ {12'h000, ch[7:4]};
        end
        return w;
    endfunction

    // Plain-arithmetic reflected polynomial division, one bit at a time.
    function automatic logic [15:0] ref_bits(input logic [7:0] msg[$]);
        int unsigned w;
        w = 32'h6363;
        foreach (msg[k]) begin
            for (int j = 0; j < 8; j++) begin
                if (((w ^ (msg[k] >> j)) & 1) != 0) w = (w / 2) ^ 32'h8408;
                else                                 w = w / 2;
            end
        end
        return w[15:0];
    endfunction

    task automatic drive_bit(input logic b);
        @(negedge clk);
        start  = 1'b0;
        sample = 1'b1;
        data   = b;
    endtask

    task automatic idle();
        @(negedge clk);
        start  = 1'b0;
        sample = 1'b0;
        data   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gap);
        for (int i = 0; i < 8; i++) begin
            drive_bit(v[i]);
            if (gap) idle();
        end
    endtask

    task automatic do_start(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            start  = 1'b1;
            sample = 1'b0;
        end
        idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; data = 1'b0; sample = 1'b0;
        #12;
        n_checks++;
        if (crc !== 16'h6363) begin
            n_fail++; $display("FAIL reset_value: got %h expected %h", crc, 16'h6363);
        end
        @(negedge clk); rst_n = 1'b1;
        do_start(1);
        idle(); idle();
        n_checks++;
        if (crc !== 16'h6363) begin
            n_fail++; $display("FAIL start_no_data: got %h expected %h", crc, 16'h6363);
        end
    endtask

    task automatic test_known_vectors();
        do_start(1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        idle();
        n_checks++;
        if (crc !== 16'h1EA0) begin
            n_fail++; $display("FAIL zeros_gapped: got %h expected %h", crc, 16'h1EA0);
        end
        do_start(3);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        idle();
        n_checks++;
        if (crc !== 16'hCF26) begin
            n_fail++; $display("FAIL vec_1234: got %h expected %h", crc, 16'hCF26);
        end
    endtask

    task automatic test_random();
        logic [7:0]  msg[$];
        logic [15:0] exp_b, exp_w;
        int          len;
        for (int m = 0; m < 1000; m++) begin
            msg.delete();
            len = $urandom_range(0, 10);
            for (int k = 0; k < len; k++) msg.push_back(8'($urandom_range(0, 255)));
            exp_b = ref_bytes(msg);
            exp_w = ref_bits(msg);
            do_start(1);
            foreach (msg[k]) send_byte(msg[k], ($urandom_range(0, 7) == 0));
            idle();
            n_checks++;
            if (crc !== exp_b || crc !== exp_w) begin
                n_fail++;
                $display("FAIL random_crc msg %0d len %0d: got %h expected %h (bitwise %h)", m, len, crc, exp_b, exp_w);
            end
            send_byte(exp_b[7:0], 1'b0);
            send_byte(exp_b[15:8], 1'b0);
            idle();
            n_checks++;
            if (crc !== 16'h0000) begin
                n_fail++; $display("FAIL random_residue msg %0d: got %h expected %h", m, crc, 16'h0000);
            end
        end
    endtask

    task automatic test_start_priority();
        do_start(1);
        send_byte(8'hA5, 1'b0);
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        @(negedge clk);
        start = 1'b1; sample = 1'b1; data = 1'b1;
        idle();
        n_checks++;
        if (crc !== 16'h6363) begin
            n_fail++; $display("FAIL start_over_sample: got %h expected %h", crc, 16'h6363);
        end
        idle(); idle();
        n_checks++;
        if (crc !== 16'h6363) begin
            n_fail++; $display("FAIL hold_no_sample: got %h expected %h", crc, 16'h6363);
        end
    endtask

    task automatic test_back_to_back_and_async_reset();
        logic [7:0] msg[$];
        do_start(1);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        idle();
        n_checks++;
        if (crc !== 16'hCF26) begin
            n_fail++; $display("FAIL b2b_1234: got %h expected %h", crc, 16'hCF26);
        end
        do_start(1);
        send_byte(8'h12, 1'b0);
        drive_bit(1'b0); drive_bit(1'b0);
        @(negedge clk);
        sample = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (crc !== 16'h6363) begin
            n_fail++; $display("FAIL async_reset: got %h expected %h", crc, 16'h6363);
        end
        @(negedge clk); rst_n = 1'b1;
        msg = '{8'h5A, 8'hC3, 8'h01};
        foreach (msg[k]) send_byte(msg[k], 1'b0);
        idle();
        n_checks++;
        if (crc !== ref_bytes(msg)) begin
            n_fail++; $display("FAIL resume_after_reset: got %h expected %h", crc, ref_bytes(msg));
        end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_start_priority();
        test_back_to_back_and_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
